// File: rtl/uart_pkg.sv
// Shared UART framing definitions: bit timing, default sync marker, parser states.
package uart_pkg;

   localparam int unsigned CLK_PER_BIT    = 87;
   localparam logic [7:0]  SYNC_BYTE_DFLT = 8'hA5;

   // Frame parser states.
   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LEN     = 2'd1,
      PAYLOAD = 2'd2,
      CHECK   = 2'd3
   } parser_state_t;

endpackage

// File: rtl/uart_frame_fifo.sv
// Payload buffer with a tentative write pointer that can be committed or rewound.
// Only entries below the commit pointer are visible to the reader.
module uart_frame_fifo #(
   parameter int unsigned DEPTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [8:0] wr_data,
   input  logic       commit,
   input  logic       rewind,
   input  logic       rd_en,
   output logic       rd_valid,
   output logic [8:0] rd_data,
   output logic       full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [8:0]    mem [DEPTH];
   logic [PW-1:0] wp_t;
   logic [PW-1:0] wp_c;
   logic [PW-1:0] rp;
   logic [PW-1:0] fill;
   logic          wr_fire;

   assign fill     = wp_t - rp;
   assign full     = (fill == PW'(DEPTH));
   assign rd_valid = (rp != wp_c);
   assign wr_fire  = wr_en & ~full;
   assign rd_data  = rd_valid ? mem[rp[AW-1:0]] : '0;

   // Storage array; no reset, reads are masked until data is committed.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wp_t[AW-1:0]] <= wr_data;
      end
   end

   // Pointer updates; a rewind only moves wp_t so committed data stays intact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_t <= '0;
         wp_c <= '0;
         rp   <= '0;
      end else begin
         if (rewind) begin
            wp_t <= wp_c;
         end else if (wr_fire) begin
            wp_t <= wp_t + 1'b1;
         end
         if (commit) begin
            wp_c <= wp_t;
         end
         if (rd_en && rd_valid) begin
            rp <= rp + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind the UART receiver: SYNC, LEN, payload, CHK.
// Payload is released downstream only once the XOR checksum matches.
module uart_rx_frame_parser
   import uart_pkg::*;
#(
   parameter int unsigned MAX_LEN      = 16,
   parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DFLT,
   parameter int unsigned TIMEOUT_CLKS = 20 * CLK_PER_BIT,
   parameter int unsigned DEPTH        = 2 * MAX_LEN
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx_dv,
   input  logic [7:0] i_rx_byte,
   output logic       o_pl_valid,
   output logic [7:0] o_pl_data,
   output logic       o_pl_last,
   input  logic       i_pl_ready,
   output logic       o_frame_ok,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

   parser_state_t state;
   logic          dv_q;
   logic          stb;
   logic [7:0]    len;
   logic [7:0]    cnt;
   logic [7:0]    chk;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          len_ok;
   logic          last_byte;

   logic          fifo_wr;
   logic          fifo_commit;
   logic          fifo_rewind;
   logic          fifo_full;
   logic [8:0]    fifo_rd_data;

   assign stb       = i_rx_dv & ~dv_q;
   assign len_ok    = (i_rx_byte != 8'd0) && (i_rx_byte <= 8'(MAX_LEN));
   assign last_byte = (cnt == len - 8'd1);
   assign tmo_hit   = (state != HUNT) && !stb && (tmo_cnt == TW'(TIMEOUT_CLKS - 1));
   assign o_busy    = (state != HUNT);

   // Edge detect on the receiver strobe so a held dv yields one byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_q <= 1'b0;
      end else begin
         dv_q <= i_rx_dv;
      end
   end

   // Buffer control decoded in the stb cycle so pointers move with the FSM.
   always_comb begin
      fifo_wr     = 1'b0;
      fifo_commit = 1'b0;
      fifo_rewind = tmo_hit;
      if (stb) begin
         case (state)
            PAYLOAD: begin
               if (fifo_full) begin
                  fifo_rewind = 1'b1;
               end else begin
                  fifo_wr = 1'b1;
               end
            end
            CHECK: begin
               if (i_rx_byte == chk) begin
                  fifo_commit = 1'b1;
               end else begin
                  fifo_rewind = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Frame FSM with checksum, length counter, timeout and registered ok/err pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         len         <= '0;
         cnt         <= '0;
         chk         <= '0;
         tmo_cnt     <= '0;
         o_frame_ok  <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_frame_ok  <= 1'b0;
         o_frame_err <= 1'b0;

         if (state == HUNT || stb || tmo_hit) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end

         case (state)
            HUNT: begin
               if (stb && i_rx_byte == SYNC_BYTE) begin
                  state <= LEN;
               end
            end
            LEN: begin
               if (stb) begin
                  if (len_ok) begin
                     len   <= i_rx_byte;
                     chk   <= i_rx_byte;
                     cnt   <= '0;
                     state <= PAYLOAD;
                  end else begin
                     o_frame_err <= 1'b1;
                     state       <= HUNT;
                  end
               end else if (tmo_hit) begin
                  o_frame_err <= 1'b1;
                  state       <= HUNT;
               end
            end
            PAYLOAD: begin
               if (stb) begin
                  if (fifo_full) begin
                     o_frame_err <= 1'b1;
                     state       <= HUNT;
                  end else begin
                     chk <= chk ^ i_rx_byte;
                     cnt <= cnt + 8'd1;
                     if (last_byte) begin
                        state <= CHECK;
                     end
                  end
               end else if (tmo_hit) begin
                  o_frame_err <= 1'b1;
                  state       <= HUNT;
               end
            end
            CHECK: begin
               if (stb) begin
                  if (i_rx_byte == chk) begin
                     o_frame_ok <= 1'b1;
                  end else begin
                     o_frame_err <= 1'b1;
                  end
                  state <= HUNT;
               end else if (tmo_hit) begin
                  o_frame_err <= 1'b1;
                  state       <= HUNT;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

   uart_frame_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (fifo_wr),
      .wr_data  ({last_byte, i_rx_byte}),
      .commit   (fifo_commit),
      .rewind   (fifo_rewind),
      .rd_en    (i_pl_ready),
      .rd_valid (o_pl_valid),
      .rd_data  (fifo_rd_data),
      .full     (fifo_full)
   );

   assign o_pl_data = fifo_rd_data[7:0];
   assign o_pl_last = fifo_rd_data[8];

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser.
module tb_uart_rx_frame_parser;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_dv;
   logic [7:0] rx_byte;
   logic       pl_ready;
   logic       pl_valid;
   logic [7:0] pl_data;
   logic       pl_last;
   logic       frame_ok;
   logic       frame_err;
   logic       busy;

   int unsigned n_tests  = 0;
   int unsigned n_failed = 0;
   int unsigned ok_cnt   = 0;
   int unsigned err_cnt  = 0;
   int unsigned both_cnt = 0;
   int unsigned rd_idx   = 0;
   logic [8:0]  got_q[$];

   uart_rx_frame_parser #(
      .MAX_LEN      (16),
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_CLKS (1740),
      .DEPTH        (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rx_dv     (rx_dv),
      .i_rx_byte   (rx_byte),
      .o_pl_valid  (pl_valid),
      .o_pl_data   (pl_data),
      .o_pl_last   (pl_last),
      .i_pl_ready  (pl_ready),
      .o_frame_ok  (frame_ok),
      .o_frame_err (frame_err),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   // Observe pulses and transfers on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_ok) ok_cnt++;
         if (frame_err) err_cnt++;
         if (frame_ok && frame_err) both_cnt++;
         if (pl_valid && pl_ready) got_q.push_back({pl_last, pl_data});
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [8:0] exp);
      logic [8:0] v;
      v = 'x;
      if (rd_idx < got_q.size()) v = got_q[rd_idx];
      rd_idx++;
      check(tag, 32'(v), 32'(exp));
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned hold);
      @(posedge clk);
      #1;
      rx_dv   = 1'b1;
      rx_byte = b;
      repeat (hold) @(posedge clk);
      #1;
      rx_dv = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int unsigned ok0;
   int unsigned err0;
   int unsigned waited;

   initial begin
      rst_n    = 1'b0;
      rx_dv    = 1'b0;
      rx_byte  = 8'h00;
      pl_ready = 1'b1;
      idle(3);
      check("rst_valid", 32'(pl_valid), 32'd0);
      check("rst_data",  32'(pl_data),  32'd0);
      check("rst_last",  32'(pl_last),  32'd0);
      check("rst_ok",    32'(frame_ok), 32'd0);
      check("rst_err",   32'(frame_err), 32'd0);
      check("rst_busy",  32'(busy),     32'd0);
      rst_n = 1'b1;
      idle(2);

      // Good frame A5 03 11 22 33 03
      ok0 = ok_cnt; err0 = err_cnt;
      send_byte(8'hA5, 1);
      check("busy_after_sync", 32'(busy), 32'd1);
      send_byte(8'h03, 1);
      send_byte(8'h11, 1);
      send_byte(8'h22, 1);
      send_byte(8'h33, 1);
      check("no_valid_before_chk", 32'(pl_valid), 32'd0);
      send_byte(8'h03, 1);
      check("ok_next_cycle",    32'(frame_ok), 32'd1);
      check("valid_next_cycle", 32'(pl_valid), 32'd1);
      check("data_next_cycle",  32'(pl_data),  32'h11);
      idle(6);
      check("good_ok",  ok_cnt - ok0, 1);
      check("good_err", err_cnt - err0, 0);
      expect_out("good_b0", 9'h011);
      expect_out("good_b1", 9'h022);
      expect_out("good_b2", 9'h133);
      check("good_count", got_q.size(), 3);
      check("good_idle",  32'(busy), 32'd0);

      // Bad checksum A5 02 AA BB 00 (correct value is 13)
      ok0 = ok_cnt; err0 = err_cnt;
      send_byte(8'hA5, 1);
      send_byte(8'h02, 1);
      send_byte(8'hAA, 1);
      send_byte(8'hBB, 1);
      send_byte(8'h00, 1);
      check("badchk_err_pulse", 32'(frame_err), 32'd1);
      idle(3);
      check("badchk_err",   err_cnt - err0, 1);
      check("badchk_ok",    ok_cnt - ok0, 0);
      check("badchk_valid", 32'(pl_valid), 32'd0);
      check("badchk_count", got_q.size(), 3);
      send_byte(8'hA5, 1);
      send_byte(8'h01, 1);
      send_byte(8'h5C, 1);
      send_byte(8'h5D, 1);
      idle(4);
      check("after_bad_ok", ok_cnt - ok0, 1);
      expect_out("after_bad_b0", 9'h15C);
      check("after_bad_count", got_q.size(), 4);

      // Noise and illegal lengths
      ok0 = ok_cnt; err0 = err_cnt;
      send_byte(8'h00, 1);
      send_byte(8'hFF, 1);
      idle(3);
      check("noise_err",  err_cnt - err0, 0);
      check("noise_busy", 32'(busy), 32'd0);
      send_byte(8'hA5, 1);
      send_byte(8'h00, 1);
      idle(2);
      check("len0_err", err_cnt - err0, 1);
      send_byte(8'hA5, 1);
      send_byte(8'h11, 1);
      idle(2);
      check("len17_err",   err_cnt - err0, 2);
      check("len_ok_cnt",  ok_cnt - ok0, 0);
      check("len_valid",   32'(pl_valid), 32'd0);
      check("len_count",   got_q.size(), 4);

      // Held dv: three cycles per byte
      ok0 = ok_cnt; err0 = err_cnt;
      send_byte(8'hA5, 3);
      send_byte(8'h03, 3);
      send_byte(8'h11, 3);
      send_byte(8'h22, 3);
      send_byte(8'h33, 3);
      send_byte(8'h03, 3);
      idle(6);
      check("held_ok",  ok_cnt - ok0, 1);
      check("held_err", err_cnt - err0, 0);
      expect_out("held_b0", 9'h011);
      expect_out("held_b1", 9'h022);
      expect_out("held_b2", 9'h133);
      check("held_count", got_q.size(), 7);

      // Backpressure: two full frames fill the buffer, third overflows
      pl_ready = 1'b0;
      ok0 = ok_cnt; err0 = err_cnt;
      for (int f = 0; f < 2; f++) begin
         send_byte(8'hA5, 1);
         send_byte(8'h10, 1);
         for (int i = 0; i < 16; i++) send_byte(8'(f * 16 + i), 1);
         send_byte(8'h10, 1);
      end
      idle(3);
      check("bp_ok",    ok_cnt - ok0, 2);
      check("bp_err",   err_cnt - err0, 0);
      check("bp_valid", 32'(pl_valid), 32'd1);
      send_byte(8'hA5, 1);
      send_byte(8'h10, 1);
      send_byte(8'h20, 1);
      check("ovf_err_pulse", 32'(frame_err), 32'd1);
      idle(3);
      check("ovf_err",   err_cnt - err0, 1);
      check("ovf_busy",  32'(busy), 32'd0);
      check("hold_data", 32'(pl_data), 32'h00);
      check("hold_last", 32'(pl_last), 32'd0);
      check("bp_count",  got_q.size(), 7);
      pl_ready = 1'b1;
      idle(40);
      for (int i = 0; i < 32; i++) begin
         expect_out("drain", {(i == 15 || i == 31), 8'(i)});
      end
      check("drain_count", got_q.size(), 39);
      check("drain_empty", 32'(pl_valid), 32'd0);

      // Timeout mid-frame
      send_byte(8'hA5, 1);
      send_byte(8'h03, 1);
      send_byte(8'h11, 1);
      err0 = err_cnt;
      idle(1700);
      check("tmo_early_err", err_cnt - err0, 0);
      check("tmo_busy",      32'(busy), 32'd1);
      waited = 0;
      while (err_cnt == err0 && waited < 200) begin
         @(posedge clk);
         waited++;
      end
      #1;
      check("tmo_err",   err_cnt - err0, 1);
      idle(2);
      check("tmo_idle",  32'(busy), 32'd0);
      check("tmo_valid", 32'(pl_valid), 32'd0);
      check("tmo_count", got_q.size(), 39);

      // Asynchronous reset while data waits to drain
      pl_ready = 1'b0;
      send_byte(8'hA5, 1);
      send_byte(8'h01, 1);
      send_byte(8'h5C, 1);
      send_byte(8'h5D, 1);
      idle(2);
      check("pre_rst_valid", 32'(pl_valid), 32'd1);
      check("pre_rst_data",  {23'd0, pl_last, pl_data}, 32'h15C);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(pl_valid), 32'd0);
      check("async_rst_data",  32'(pl_data),  32'd0);
      idle(2);
      rst_n    = 1'b1;
      pl_ready = 1'b1;
      idle(4);
      check("post_rst_valid", 32'(pl_valid), 32'd0);
      check("post_rst_count", got_q.size(), 39);

      check("ok_err_exclusive", both_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_parser.md
# uart_rx_frame_parser

Framing stage directly downstream of the UART receiver. It consumes the receiver's byte-valid strobe and byte, and hunts for frames of the form SYNC, LEN, payload, CHK. Payload bytes are held in a commit/rewind buffer and released to the consumer over a valid/ready stream only after the checksum passes. Bad, oversize or stalled frames are discarded whole, with no partial payload ever exposed.

## Interface
- MAX_LEN, 16: maximum payload bytes per frame (1..255).
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CLKS, 1740: inter-byte timeout in clocks (20 bit times at 87 clk/bit).
- DEPTH, 2*MAX_LEN: payload buffer entries (power of two).
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_rx_dv  in  1  receiver byte-valid; may stay high for more than one cycle per byte.
- i_rx_byte  in  8  receiver byte; stable while i_rx_dv is high.
- o_pl_valid  out  1  payload byte available.
- o_pl_data  out  8  payload byte.
- o_pl_last  out  1  final payload byte of its frame (qualified by o_pl_valid).
- i_pl_ready  in  1  consumer accepts; transfer when o_pl_valid & i_pl_ready.
- o_frame_ok  out  1  one-cycle pulse: frame committed.
- o_frame_err  out  1  one-cycle pulse: frame discarded.
- o_busy  out  1  FSM not in HUNT.

## Operation
- Byte strobe: stb = i_rx_dv & ~dv_q, where dv_q is i_rx_dv registered. Exactly one stb per rising edge of i_rx_dv. i_rx_byte is captured on stb.
- FSM states: HUNT, LEN, PAYLOAD, CHECK.
- HUNT: on stb with byte == SYNC_BYTE, go to LEN. Any other byte is ignored silently (no err).
- LEN: on stb, if 1 <= byte <= MAX_LEN, latch len, set chk = byte, clear cnt, go to PAYLOAD. Otherwise pulse err and go to HUNT.
- PAYLOAD: on stb, write {last = (cnt == len-1), byte} at the tentative pointer wp_t, then wp_t++, chk ^= byte, cnt++. After the len-th byte, go to CHECK.
- CHECK: on stb, if byte == chk, set commit pointer wp_c = wp_t, pulse ok, and go to HUNT. Otherwise rewind wp_t = wp_c, pulse err, and go to HUNT.
- Overflow: in PAYLOAD, if stb arrives while (wp_t - rp) == DEPTH, the byte is not written. Rewind, pulse err, go to HUNT.
- Timeout: a counter clears on every stb and on entry to HUNT, and counts in LEN, PAYLOAD and CHECK. On reaching TIMEOUT_CLKS-1, rewind, pulse err, go to HUNT.
- Output side: o_pl_valid = (rp != wp_c). o_pl_data and o_pl_last are read combinationally at rp. rp++ on transfer.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full/empty are decided by the MSB-extended difference.
- Committed data is never affected by a rewind.

## Timing
- Reset values: o_pl_valid 0, o_pl_data 0, o_pl_last 0, o_frame_ok 0, o_frame_err 0, o_busy 0. State is HUNT; rp, wp_t, wp_c, dv_q, cnt and the timeout counter are all 0.
- Reset mid-frame or mid-drain flushes everything, committed data included.
- stb is asserted in the cycle after i_rx_dv rises. FSM, pointer and chk updates occur at the end of the stb cycle.
- The CHK byte's stb in cycle N produces o_frame_ok = 1 in cycle N+1 (registered). o_pl_valid rises in N+1 if the buffer was empty.
- o_frame_err is registered, high in the cycle after the triggering stb or timeout terminal count.
- A transfer and a commit in the same cycle are both honoured. A transfer and a rewind in the same cycle are both honoured (rewind touches only wp_t).
- o_pl_data and o_pl_last hold stable while o_pl_valid & ~i_pl_ready.
- ok and err are never high together, and each is at most one cycle per frame.

## Structure
- Shared package uart_pkg: CLK_PER_BIT = 87, SYNC_BYTE default, parser state enum (HUNT/LEN/PAYLOAD/CHECK).
- One sub-module: uart_frame_fifo, a DEPTH x 9 buffer with tentative write, commit, rewind and read ports, holding all pointer arithmetic.
- The parser top holds the edge detect, FSM, checksum, length counter and timeout.

## Test plan
- Good frame: stb bytes A5 03 11 22 33 03, i_pl_ready = 1. Response: one ok pulse, then 11, 22, 33 out with last on 33, and no err.
- Bad checksum: A5 02 AA BB 00 (expected 13). Response: err pulse, o_pl_valid stays 0, wp_c unchanged. A following good frame A5 01 5C 5D drains 5C with last.
- Noise and bad length: bytes 00 FF, then A5 00, then A5 11 with MAX_LEN = 16. Response: no err for the noise, one err for LEN = 0, one err for LEN = 0x11, and no output.
- Held dv: i_rx_dv held high for 3 cycles per byte on the good frame. Response: exactly one stb per byte and the output is identical to the first scenario.
- Backpressure and overflow: i_pl_ready = 0, two committed 16-byte frames, then a third frame. Response: err on the 33rd payload byte, and the 32 committed bytes drain intact once ready = 1.
- Timeout and reset: A5 03 11, then 1740 idle clocks. Response: err pulse and no output. Asserting rst_n low mid-drain clears o_pl_valid immediately (async).
